cdb_arb: RTL and testbench

CDB_ARB -- requirements
Module: cdb_arb

---
 rtl/cdb_arb_pkg.sv | 27 ++
 rtl/cdb_arb_fifo.sv | 65 ++++++
 rtl/cdb_arb.sv | 99 +++++++++
 tb/tb_cdb_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arb_pkg.sv
// cdb_arb_pkg -- shared definitions for the common data bus (CDB) arbiter.
//   TAG_WIDTH   : width of a destination (reservation-station) tag
//   DATA_WIDTH  : width of a result word
//   cdb_entry_t : {tag, data} as stored in a per-requester result buffer
//   cdb_t       : {valid, tag, data} as broadcast on the CDB
package cdb_arb_pkg;

    localparam int TAG_WIDTH  = 6;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_t;

    // Round-robin successor of index v among n slots.
    function automatic int rr_succ(input int v, input int n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/cdb_arb_fifo.sv
// cdb_arb_fifo -- result buffer for one functional unit feeding the CDB.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the buffer)
//   push       : write wdata at the tail this cycle (caller guarantees room,
//                which includes the full-and-popping case)
//   pop        : drop the head entry this cycle (caller guarantees non-empty)
//   wdata      : entry to write
//   head       : current head entry (valid only while !empty)
//   empty/full : occupancy flags
// Push and pop may occur together in any state, including full; the count is
// then unchanged and the head read this cycle is the pre-pop entry.
module cdb_arb_fifo
    import cdb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t wdata,
    output cdb_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arb.sv
// cdb_arb -- round-robin arbiter placing one buffered functional-unit result
// per cycle onto the common data bus.
// Ports:
//   clk, reset : clock; synchronous active-high reset, also the mispredict flush
//   req_valid  : requester i offers {req_tag[i], req_data[i]} this cycle
//   req_ready  : arbiter accepts requester i's offer this cycle
//   req_tag    : per-requester destination tag
//   req_data   : per-requester result data
//   cdb        : registered broadcast {valid, tag, data}
//   grant      : registered one-hot source of the current cdb (0 when idle)
// Handshake: a result transfers on a cycle where req_valid[i] && req_ready[i]
// at the rising edge. req_ready never depends on req_valid; it is high when
// the buffer has room, or when it is full but its head is being popped this
// cycle. Offers are never bypassed to the bus: every result is buffered first,
// so the earliest it can appear on cdb is one edge after it was accepted.
module cdb_arb
    import cdb_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ-1:0][TAG_WIDTH-1:0]      req_tag,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_data,
    output cdb_t                                 cdb,
    output logic [N_REQ-1:0]                     grant
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic             any_win;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] fifo_empty;
    logic [N_REQ-1:0] fifo_full;
    logic [N_REQ-1:0] push;
    cdb_entry_t       head [N_REQ];
    int               cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        cdb_entry_t wdata;
        assign wdata = '{tag: req_tag[i], data: req_data[i]};

        cdb_arb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (win_oh[i]),
            .wdata (wdata),
            .head  (head[i]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );
    end

    // Scan from rr_ptr upwards with wrap; the first non-empty buffer wins.
    // Only buffered state is examined, so ready has no path from req_valid.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any_win = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!any_win && !fifo_empty[cand]) begin
                any_win      = 1'b1;
                win_idx      = IDX_W'(cand);
                win_oh[cand] = 1'b1;
            end
        end
    end

    assign req_ready = ~fifo_full | win_oh;
    assign push      = req_valid & req_ready;

    // tag/data keep their last value when idle and are not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb.valid <= 1'b0;
            grant     <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb.valid <= any_win;
            grant     <= win_oh;
            if (any_win) begin
                cdb.tag  <= head[win_idx].tag;
                cdb.data <= head[win_idx].data;
                rr_ptr   <= IDX_W'(rr_succ(int'(win_idx), N_REQ));
            end
        end
    end

endmodule

// File: tb/tb_cdb_arb.sv
module tb_cdb_arb;
    import cdb_arb_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int EW    = TAG_WIDTH + DATA_WIDTH;

    logic                             clk;
    logic                             reset;
    logic [N-1:0]                     req_valid;
    logic [N-1:0]                     req_ready;
    logic [N-1:0][TAG_WIDTH-1:0]      req_tag;
    logic [N-1:0][DATA_WIDTH-1:0]     req_data;
    cdb_t                             cdb;
    logic [N-1:0]                     grant;

    cdb_arb #(
        .N_REQ      (N),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .cdb       (cdb),
        .grant     (grant)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each requester's buffer is a queue; the arbiter is "first non-empty
    // queue scanning from m_rr"; bus contents are whatever was last popped.
    logic [EW-1:0]          exp_q [N][$];
    int                     m_rr;
    logic                   m_known;
    logic [TAG_WIDTH-1:0]   m_tag;
    logic [DATA_WIDTH-1:0]  m_data;
    logic [N-1:0]           acc;

    int n_assert;
    int n_fail;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: inputs were driven just after the previous edge.
    task automatic cycle();
        int             w;
        logic [N-1:0]   exp_rdy;
        logic [N-1:0]   exp_g;
        logic           exp_v;
        logic [EW-1:0]  ent;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (w < 0 && exp_q[c].size() != 0) w = c;
        end
        for (int i = 0; i < N; i++)
            exp_rdy[i] = (exp_q[i].size() < DEPTH) || (w == i);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        acc   = req_valid & exp_rdy;
        exp_v = 1'b0;
        exp_g = '0;
        if (w >= 0) begin
            ent      = exp_q[w].pop_front();
            exp_v    = 1'b1;
            exp_g[w] = 1'b1;
            m_tag    = ent[EW-1:DATA_WIDTH];
            m_data   = ent[DATA_WIDTH-1:0];
            m_known  = 1'b1;
            m_rr     = (w + 1) % N;
        end
        for (int i = 0; i < N; i++)
            if (acc[i]) exp_q[i].push_back({req_tag[i], req_data[i]});
        @(posedge clk);
        #1;
        check("cdb_valid", 64'(cdb.valid), 64'(exp_v));
        check("grant", 64'(grant), 64'(exp_g));
        if (m_known) begin
            check("cdb_tag", 64'(cdb.tag), 64'(m_tag));
            check("cdb_data", 64'(cdb.data), 64'(m_data));
        end
    endtask

    // One-cycle reset; whatever is offered meanwhile is discarded.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        m_rr    = 0;
        m_known = 1'b0;
        acc     = '0;
        check("rst_cdb_valid", 64'(cdb.valid), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ready", 64'(req_ready), 64'({N{1'b1}}));
    endtask

    task automatic offer(input int i, input int tag);
        req_valid[i] = 1'b1;
        req_tag[i]   = TAG_WIDTH'(tag);
        req_data[i]  = $urandom;
    endtask

    // ---------------- stimulus ----------------
    logic [TAG_WIDTH-1:0] obs1 [$];
    int                   p;
    int                   k_push;
    int                   lat;
    int                   seen;
    logic                 saw_stall;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        m_rr      = 0;
        m_known   = 1'b0;
        m_tag     = '0;
        m_data    = '0;
        acc       = '0;
        do_reset();

        // single requester: tag 5 / 0x1234 from requester 2
        req_valid   = 4'b0100;
        req_tag[2]  = 6'd5;
        req_data[2] = 32'h1234;
        cycle();
        req_valid = '0;
        cycle();
        check("single_valid", 64'(cdb.valid), 64'd1);
        check("single_tag", 64'(cdb.tag), 64'd5);
        check("single_data", 64'(cdb.data), 64'h1234);
        check("single_grant", 64'(grant), 64'b0100);
        cycle();
        check("single_idle", 64'(cdb.valid), 64'd0);

        // full contention from rr_ptr = 0
        do_reset();
        for (int i = 0; i < N; i++) offer(i, 10 + i);
        cycle();
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            cycle();
            check("contend_grant", 64'(grant), 64'(1) << k);
        end
        for (int i = 0; i < N; i++) offer(i, 20 + i);
        cycle();
        req_valid = '0;
        cycle();
        check("contend_wrap", 64'(grant), 64'b0001);
        for (int k = 0; k < N; k++) cycle();

        // backpressure: 0,2,3 busy, requester 1 offers a,b,c and holds
        do_reset();
        p = 0;
        saw_stall = 1'b0;
        obs1.delete();
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++)
                if (i != 1) begin
                    req_valid[i] = (k < 10);
                    req_tag[i]   = TAG_WIDTH'(i);
                    req_data[i]  = $urandom;
                end
            req_valid[1] = (k >= 2) && (p < 3);
            req_tag[1]   = TAG_WIDTH'(17 + p);
            req_data[1]  = 32'(p);
            if (req_valid[1] && !req_ready[1]) saw_stall = 1'b1;
            cycle();
            if (acc[1]) p++;
            if (grant[1]) obs1.push_back(cdb.tag);
        end
        req_valid = '0;
        check("bp_stalled", 64'(saw_stall), 64'd1);
        check("bp_count", 64'(obs1.size()), 64'd3);
        if (obs1.size() == 3) begin
            check("bp_order_a", 64'(obs1[0]), 64'd17);
            check("bp_order_b", 64'(obs1[1]), 64'd18);
            check("bp_order_c", 64'(obs1[2]), 64'd19);
        end

        // full FIFO 3 pushed while it wins
        do_reset();
        for (int i = 0; i < N; i++) offer(i, 30 + i);
        cycle();
        req_valid = '0;
        offer(3, 40);
        cycle();
        offer(3, 41);
        check("full_ready_c2", 64'(req_ready[3]), 64'd0);
        cycle();
        check("full_ready_c3", 64'(req_ready[3]), 64'd0);
        cycle();
        check("full_ready_win", 64'(req_ready[3]), 64'd1);
        cycle();
        req_valid = '0;
        check("full_win_grant", 64'(grant), 64'b1000);
        cycle();
        check("full_drain1", 64'(grant), 64'b1000);
        cycle();
        check("full_drain2", 64'(grant), 64'b1000);
        check("full_drain2_tag", 64'(cdb.tag), 64'd41);
        cycle();
        check("full_empty", 64'(cdb.valid), 64'd0);

        // reset with five results buffered
        do_reset();
        for (int i = 0; i < N; i++) offer(i, 50 + i);
        cycle();
        req_valid = '0;
        offer(1, 55);
        offer(2, 56);
        cycle();
        req_valid = '1;
        do_reset();
        req_valid = '0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (cdb.valid) seen++;
        end
        check("flush_no_stale", 64'(seen), 64'd0);

        // fairness: requester 0 always busy, requester 3 one result
        do_reset();
        k_push = -1;
        lat    = 99;
        for (int k = 0; k < 12; k++) begin
            offer(0, 1);
            req_valid[3] = (k == 3);
            req_tag[3]   = 6'd9;
            req_data[3]  = 32'hfeed;
            cycle();
            if (acc[3]) k_push = k;
            if (grant[3] && lat == 99 && k_push >= 0) lat = k - k_push;
        end
        req_valid = '0;
        check("fair_accepted", 64'(k_push), 64'd3);
        check("fair_bound", 64'(lat >= 1 && lat <= N), 64'd1);
        for (int k = 0; k < 4; k++) cycle();

        // randomized traffic with held offers and occasional flush
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                if ($urandom_range(0, 1) == 1) req_valid = '1;
                do_reset();
            end
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 25 + 15 * i);
                    req_tag[i]   = TAG_WIDTH'($urandom_range(0, 63));
                    req_data[i]  = $urandom;
                end
            cycle();
        end
        req_valid = '0;
        for (int k = 0; k < 10; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
